// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Optional DIV_FAST_EN: divide-by-zero and |dividend| < |divisor| retire straight from IDLE.
module div_radix2 (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] operand1,
   input  logic [63:0] operand2,
   input  logic [2:0]  div_op,
   input  logic        req_valid,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [63:0] resp_result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [63:0] rem, quo, dvs, a_orig;
   logic        op_rem, op_w, q_neg, r_neg, dz;

   // request decode: width extension, signs and magnitudes
   logic        req_uns, req_w, sa, sb, req_dz;
   logic [63:0] a_ext, b_ext, a_mag, b_mag;

   always_comb begin
      req_uns = div_op[0];
      req_w   = div_op[2];
      if (req_w) begin
         a_ext = req_uns ? {32'b0, operand1[31:0]} : {{32{operand1[31]}}, operand1[31:0]};
         b_ext = req_uns ? {32'b0, operand2[31:0]} : {{32{operand2[31]}}, operand2[31:0]};
      end else begin
         a_ext = operand1;
         b_ext = operand2;
      end
      sa     = !req_uns && a_ext[63];
      sb     = !req_uns && b_ext[63];
      a_mag  = sa ? -a_ext : a_ext;
      b_mag  = sb ? -b_ext : b_ext;
      req_dz = (b_ext == 64'd0);
   end

   // one restoring step; a passing 65-bit trial leaves a difference below the divisor
   logic [64:0] r_sh;
   logic        ge;
   logic [63:0] rem_nxt, quo_nxt;

   always_comb begin
      r_sh    = {rem, quo[63]};
      ge      = (r_sh >= {1'b0, dvs});
      rem_nxt = ge ? (r_sh[63:0] - dvs) : r_sh[63:0];
      quo_nxt = {quo[62:0], ge};
   end

   logic [63:0] q_fix, r_fix, sel, fix_res;

   always_comb begin
      q_fix = q_neg ? -quo : quo;
      r_fix = r_neg ? -rem : rem;
      if (dz) begin
         q_fix = '1;
         r_fix = a_orig;
      end
      sel     = op_rem ? r_fix : q_fix;
      fix_res = op_w ? {{32{sel[31]}}, sel[31:0]} : sel;
   end

`ifdef DIV_FAST_EN
   logic        fast_hit;
   logic [63:0] fast_sel, fast_res;

   always_comb begin
      fast_hit = req_dz || (a_mag < b_mag);
      fast_sel = div_op[1] ? a_ext : (req_dz ? '1 : '0);
      fast_res = req_w ? {{32{fast_sel[31]}}, fast_sel[31:0]} : fast_sel;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         a_orig      <= '0;
         op_rem      <= 1'b0;
         op_w        <= 1'b0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dz          <= 1'b0;
         resp_result <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               op_rem <= div_op[1];
               op_w   <= req_w;
               q_neg  <= sa ^ sb;
               r_neg  <= sa;
               dz     <= req_dz;
               a_orig <= a_ext;
               dvs    <= b_mag;
               rem    <= '0;
               // W dividends are parked in the top half so 32 steps consume them
               quo    <= req_w ? {a_mag[31:0], 32'b0} : a_mag;
               cnt    <= req_w ? 6'd31 : 6'd63;
`ifdef DIV_FAST_EN
               if (fast_hit) begin
                  resp_result <= fast_res;
                  state       <= DONE;
               end else begin
                  state <= CALC;
               end
`else
               state  <= CALC;
`endif
            end
            CALC: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (cnt == 6'd0) state <= FIX;
               else             cnt   <= cnt - 6'd1;
            end
            FIX: begin
               resp_result <= fix_res;
               state       <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_div_radix2.sv
// Directed-vector bench for div_radix2: results, latency, handshake and mid-op reset.
module tb_div_radix2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] operand1 = '0, operand2 = '0;
   logic [2:0]  div_op = '0;
   logic        req_valid = 1'b0;
   logic        req_ready, resp_valid;
   logic [63:0] resp_result;

   int nvec = 0;
   int nerr = 0;

`ifdef DIV_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   div_radix2 dut (
      .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2), .div_op(div_op),
      .req_valid(req_valid), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_result(resp_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int fl(input int n);
      return FAST ? 1 : n;
   endfunction

   // starts just after the acceptance edge; ends at the negedge following the pulse
   task automatic wait_resp(input string tag, input logic [63:0] exp, input int exp_lat);
      int cyc = 0;
      bit got = 0;
      while (!got && cyc < 200) begin
         cyc++;
         @(negedge clk);
         if (cyc == 1) chk({tag, "_busy"}, 64'(req_ready), 64'd0);
         if (resp_valid) got = 1;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      chk({tag, "_res"}, resp_result, exp);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(resp_valid), 64'd0);
      chk({tag, "_idle"}, 64'(req_ready), 64'd1);
      chk({tag, "_hold"}, resp_result, exp);
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op, input logic [63:0] exp, input int exp_lat);
      @(negedge clk);
      operand1  = a;
      operand2  = b;
      div_op    = op;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      operand1  = ~a;
      operand2  = ~b;
      div_op    = ~op;
      wait_resp(tag, exp, exp_lat);
   endtask

   initial begin
      int stale;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_result", resp_result, 64'd0);
      rst = 1'b1;

      // op: bit0 unsigned, bit1 remainder, bit2 word
      run_op("div_100_7",   64'd100, 64'd7, 3'b000, 64'd14, 66);
      run_op("remu_100_7",  64'd100, 64'd7, 3'b011, 64'd2, 66);
      run_op("div_m7_2",    -64'sd7, 64'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 66);
      run_op("rem_m7_2",    -64'sd7, 64'd2, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 66);
      run_op("rem_7_m2",    64'd7, -64'sd2, 3'b010, 64'd1, 66);
      run_op("divu_5_0",    64'd5, 64'd0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, fl(66));
      run_op("rem_5_0",     64'd5, 64'd0, 3'b010, 64'd5, fl(66));
      run_op("div_ovf",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000,
             64'h8000_0000_0000_0000, 66);
      run_op("rem_ovf",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010,
             64'd0, 66);
      run_op("divu_max_2",  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b001, 64'h7FFF_FFFF_FFFF_FFFF, 66);
      run_op("divu_3_10",   64'd3, 64'd10, 3'b001, 64'd0, fl(66));
      run_op("remu_3_10",   64'd3, 64'd10, 3'b011, 64'd3, fl(66));
      run_op("divw_ovf",    64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'b100,
             64'hFFFF_FFFF_8000_0000, 34);
      run_op("divuw_max_1", 64'h0000_0000_FFFF_FFFF, 64'd1, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 34);
      run_op("remuw_f_16",  64'h0000_0000_FFFF_FFFF, 64'd16, 3'b111, 64'd15, 34);
      run_op("divw_hi_junk", 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 3'b100,
             64'hFFFF_FFFF_FFFF_FFFD, 34);
      run_op("remw_5_0",    64'h1111_2222_0000_0005, 64'hABCD_0000_0000_0000, 3'b110,
             64'd5, fl(34));

      // back-to-back with req_valid held: second op waits for the cycle after DONE
      @(negedge clk);
      operand1 = 64'd100; operand2 = 64'd7; div_op = 3'b000; req_valid = 1'b1;
      @(posedge clk);
      #1;
      operand1 = 64'd200; operand2 = 64'd3;
      wait_resp("b2b_first", 64'd14, 66);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_resp("b2b_second", 64'd66, 66);

      // reset in cycle 20 of an op drops it without a response
      @(negedge clk);
      operand1 = 64'd100; operand2 = 64'd7; div_op = 3'b000; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'd1);
      chk("mid_rst_valid", 64'(resp_valid), 64'd0);
      chk("mid_rst_result", resp_result, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      stale = 0;
      repeat (80) begin
         @(negedge clk);
         if (resp_valid) stale++;
      end
      chk("mid_rst_stale", 64'(stale), 64'd0);

      run_op("after_rst", 64'd100, 64'd7, 3'b000, 64'd14, 66);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative radix-2 restoring integer divider for the RV64M divide/remainder group. It is the responder side of the multiply/divide unit's `req_valid`/`req_ready`/`resp_valid`/`resp_result` protocol, and it sits behind the md dispatcher as its divide unit. It accepts one operation at a time, retires one quotient bit per cycle, and returns a single-cycle result pulse. It covers DIV, DIVU, REM and REMU, plus their 32-bit W variants.

## Interface
- No parameters. XLEN is fixed at 64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low: asserting low forces reset state immediately; deassertion is released synchronously to `clk`.
- `operand1`  in  64  dividend; sampled only on acceptance.
- `operand2`  in  64  divisor; sampled only on acceptance.
- `div_op`  in  3  operation select, sampled on acceptance:
  - bit0: 1 = unsigned, 0 = signed.
  - bit1: 1 = remainder, 0 = quotient.
  - bit2: 1 = word (W) op, 0 = 64-bit op.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `resp_valid`  out  1  one-cycle result pulse; there is no back-pressure.
- `resp_result`  out  64  result, registered; holds its last value until the next DONE.

## Operation
- State machine: IDLE, CALC, FIX, DONE.
- IDLE:
  - `req_valid && req_ready` accepts the request and latches the op flags.
  - Latches |dividend| and |divisor| in the 64-bit unsigned working registers.
  - Records the quotient sign (sign(a) ^ sign(b)) and the remainder sign (sign(a)).
  - Loads the iteration counter with N-1, where N = 64 for 64-bit ops and 32 for W ops. Goes to CALC.
- Absolute values are taken only for signed ops. Unsigned ops use the operands as-is.
- W ops use `operandX[31:0]`. Signed W ops sign-extend from bit 31; unsigned W ops zero-extend.
- CALC, once per cycle:
  - Shift the remainder:dividend pair left by 1.
  - Trial-subtract the divisor (65-bit subtraction). If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - When the counter reaches 0, go to FIX; otherwise decrement.
- FIX:
  - Negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Select quotient or remainder per bit1.
  - For W ops, the final value is `{{32{r[31]}}, r[31:0]}`. This sign-extension applies to DIVUW and REMUW as well.
  - Write `resp_result`, then go to DONE.
- DONE: `resp_valid` = 1 for exactly this cycle, then return to IDLE.
- Divide by zero: quotient = all ones, remainder = original dividend (W: sign-extended low 32 bits). This result is forced in FIX, overriding the sign fix-up.
- Signed overflow (most-negative / -1) needs no special handling. The unsigned magnitude path produces quotient = dividend and remainder = 0 (W: 0xFFFF_FFFF_8000_0000).
- `req_valid` while not in IDLE is ignored; the request is not captured and has no side effects.
- Reset mid-operation: state goes to IDLE immediately and no `resp_valid` is issued for the dropped op.
- There is no abort input. The requester masks a response it does not want.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready` = 1
  - `resp_valid` = 0
  - `resp_result` = 0
  - counter = 0
- Cycle 0 is the acceptance cycle. CALC occupies cycles 1..N, FIX is cycle N+1, and `resp_valid` is high in cycle N+2.
  - 64-bit ops: `resp_valid` in cycle 66.
  - W ops: `resp_valid` in cycle 34.
- `req_ready` is low from cycle 1 through DONE inclusive. The earliest next acceptance is the cycle after DONE.
- `resp_result` is valid in the same cycle as `resp_valid`.

## Configuration
- Macro: `DIV_FAST_EN`.
- Defined: the following cases go from IDLE directly to DONE, with `resp_valid` in cycle 1 and the result computed in the acceptance cycle:
  - divisor = 0 (zero in the low 32 bits for W ops);
  - |dividend| < |divisor| (compared in the op's width): quotient = 0, remainder = original dividend, W results sign-extended.
- Undefined: every op takes the full N+2 latency. Results are identical either way.

## Test plan
- DIV 100 / 7 → `resp_result` = 14 with `resp_valid` in cycle 66. REMU 100 / 7 → 2.
- DIV -7 / 2 → 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7 / 2 → 0xFFFF_FFFF_FFFF_FFFF (-1). REM 7 / -2 → 1.
- Divide by zero:
  - DIVU 5 / 0 → 0xFFFF_FFFF_FFFF_FFFF. REM 5 / 0 → 5.
  - `resp_valid` in cycle 1 with `DIV_FAST_EN` defined, cycle 66 without.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000. REM of the same → 0.
- W ops:
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 in cycle 34.
  - DIVUW 0xFFFF_FFFF / 1 → 0xFFFF_FFFF_FFFF_FFFF.
- Hold `req_valid` high throughout: the second request is accepted only in the cycle after DONE. Assert `rst` low in cycle 20 of an op: `req_ready` = 1 and `resp_valid` = 0 immediately, and no stale `resp_valid` pulse appears afterward.
